// File: rtl/rst_sequencer.sv
// Reset sequencer: async-assert / sync-deassert of the board reset, followed by a
// Lock-qualified hold stretch, with software- and lock-loss re-entry into reset.
module rst_sequencer #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 8
) (
   input  logic       Clk,
   input  logic       Rst_l,
   input  logic       Lock,
   input  logic       Sw_Rst_Req,
   output logic       Rst_Out_l,
   output logic       Rst_Done,
   output logic [1:0] State,
   output logic [7:0] Sw_Rst_Count
);

   typedef enum logic [1:0] {
      ST_RESET  = 2'b00,
      ST_HOLD   = 2'b01,
      ST_RUN    = 2'b10,
      ST_UNUSED = 2'b11
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [7:0]             cnt_q, cnt_d;
   logic                   sw_accept;

   // Plain shift chain: nothing may sit between the synchronizer flops.
   always_ff @(posedge Clk or negedge Rst_l) begin
      if (!Rst_l) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge Clk or negedge Rst_l) begin
      if (!Rst_l) begin
         state_q      <= ST_RESET;
         cnt_q        <= '0;
         Rst_Out_l    <= 1'b0;
         Rst_Done     <= 1'b0;
         Sw_Rst_Count <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         Rst_Out_l <= (state_d == ST_RUN);
         Rst_Done  <= (state_d == ST_RUN) && (state_q != ST_RUN);
         if (sw_accept && (Sw_Rst_Count != '1))
            Sw_Rst_Count <= Sw_Rst_Count + 8'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sw_accept = 1'b0;
      case (state_q)
         ST_RESET: begin
            if (synced) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            // A software request restarts the stretch regardless of Lock.
            if (Sw_Rst_Req || !Lock)     cnt_d   = '0;
            else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
            else                         cnt_d   = cnt_q + 8'd1;
         end
         ST_RUN: begin
            if (Sw_Rst_Req || !Lock) begin
               state_d   = ST_HOLD;
               cnt_d     = '0;
               sw_accept = Sw_Rst_Req;
            end
         end
         default: begin
            state_d = ST_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      State = state_q;
   end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a rule-level reference model.
module tb_rst_sequencer;

   localparam int SYNC = 2;
   localparam int HOLD = 8;

   logic       Clk;
   logic       Rst_l;
   logic       Lock;
   logic       Sw_Rst_Req;
   logic       Rst_Out_l;
   logic       Rst_Done;
   logic [1:0] State;
   logic [7:0] Sw_Rst_Count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: edges since release, phase as reported on State,
   // and the run of qualifying Lock-high edges seen in the hold phase.
   int m_age, m_phase, m_streak, m_out, m_done, m_cnt;

   rst_sequencer #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
      .Clk          (Clk),
      .Rst_l        (Rst_l),
      .Lock         (Lock),
      .Sw_Rst_Req   (Sw_Rst_Req),
      .Rst_Out_l    (Rst_Out_l),
      .Rst_Done     (Rst_Done),
      .State        (State),
      .Sw_Rst_Count (Sw_Rst_Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_age    = 0;
      m_phase  = 0;
      m_streak = 0;
      m_out    = 0;
      m_done   = 0;
      m_cnt    = 0;
   endfunction

   function automatic void model_edge(input bit lock, input bit req);
      bit pre_synced;
      pre_synced = (m_age >= SYNC);
      if (m_age < 1000) m_age++;
      m_done = 0;
      case (m_phase)
         0: if (pre_synced) begin m_phase = 1; m_streak = 0; end
         1: begin
            if (req || !lock) m_streak = 0;
            else begin
               m_streak++;
               if (m_streak == HOLD) begin m_phase = 2; m_done = 1; end
            end
         end
         default: begin
            if (req || !lock) begin
               m_phase  = 1;
               m_streak = 0;
               if (req && m_cnt < 255) m_cnt++;
            end
         end
      endcase
      m_out = (m_phase == 2) ? 1 : 0;
   endfunction

   task automatic compare_all(input string ctx);
      check_eq({ctx, ".rst_out"}, int'(Rst_Out_l),    m_out);
      check_eq({ctx, ".done"},    int'(Rst_Done),     m_done);
      check_eq({ctx, ".state"},   int'(State),        m_phase);
      check_eq({ctx, ".count"},   int'(Sw_Rst_Count), m_cnt);
   endtask

   // Inputs change on the falling edge; a low Rst_l is checked before the next rising edge.
   task automatic step(input bit r, input bit l, input bit q);
      @(negedge Clk);
      Rst_l      = r;
      Lock       = l;
      Sw_Rst_Req = q;
      if (!r) begin
         model_reset();
         #1 compare_all("async");
      end
      @(posedge Clk);
      if (Rst_l) model_edge(Lock, Sw_Rst_Req);
      else       model_reset();
      #1 compare_all("edge");
   endtask

   task automatic release_check();
      for (int k = 1; k <= 12; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k == SYNC)              check_eq("rel.still_reset", int'(State), 0);
         if (k == SYNC + 1)          check_eq("rel.hold_entry", int'(State), 1);
         if (k == SYNC + HOLD)       check_eq("rel.low_edge10", int'(Rst_Out_l), 0);
         if (k == SYNC + HOLD + 1) begin
            check_eq("rel.high_edge11", int'(Rst_Out_l), 1);
            check_eq("rel.done_edge11", int'(Rst_Done), 1);
            check_eq("rel.run_state",   int'(State), 2);
         end
         if (k == SYNC + HOLD + 2)   check_eq("rel.done_cleared", int'(Rst_Done), 0);
      end
   endtask

   task automatic recover();
      repeat (HOLD + 1) step(1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      Rst_l = 1'b1; Lock = 1'b1; Sw_Rst_Req = 1'b0;
      model_reset();
      #1 Rst_l = 1'b0;
      #1 compare_all("por");
      check_eq("por.rst_out_const", int'(Rst_Out_l), 0);

      repeat (3) step(1'b0, 1'b1, 1'b0);
      release_check();

      // Lock loss from RUN, then a lock dropout partway through the stretch.
      step(1'b1, 1'b0, 1'b0);
      check_eq("lockloss.count", int'(Sw_Rst_Count), 0);
      check_eq("lockloss.state", int'(State), 1);
      repeat (5) step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= HOLD; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k == HOLD - 1) check_eq("dropout.low", int'(Rst_Out_l), 0);
         if (k == HOLD)     check_eq("dropout.high", int'(Rst_Out_l), 1);
      end

      // Single-cycle software reset.
      step(1'b1, 1'b1, 1'b1);
      check_eq("sw.assert", int'(Rst_Out_l), 0);
      check_eq("sw.count1", int'(Sw_Rst_Count), 1);
      for (int k = 1; k <= HOLD; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k == HOLD - 1) check_eq("sw.low_last", int'(Rst_Out_l), 0);
         if (k == HOLD)     check_eq("sw.high", int'(Rst_Out_l), 1);
      end

      // Request together with lock loss counts; lock loss alone does not.
      step(1'b1, 1'b0, 1'b1);
      check_eq("both.count", int'(Sw_Rst_Count), 2);
      recover();
      step(1'b1, 1'b0, 1'b0);
      check_eq("lockonly.count", int'(Sw_Rst_Count), 2);
      recover();

      // Held request stays in HOLD and counts once.
      repeat (20) step(1'b1, 1'b1, 1'b1);
      check_eq("held.count", int'(Sw_Rst_Count), 3);
      recover();

      // Saturation.
      repeat (256) begin
         step(1'b1, 1'b1, 1'b1);
         recover();
      end
      check_eq("sat.count", int'(Sw_Rst_Count), 255);

      // Async reset mid-HOLD, then mid-RUN, each followed by a full release.
      step(1'b1, 1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_eq("midhold.count", int'(Sw_Rst_Count), 0);
      release_check();
      step(1'b1, 1'b1, 1'b1);
      recover();
      step(1'b0, 1'b1, 1'b0);
      check_eq("midrun.rst_out", int'(Rst_Out_l), 0);
      release_check();

      repeat (3000)
         step(1'b1 && ($urandom_range(0, 199) != 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 29) == 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
